// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: oversampled SPI slave register bank, all CPOL/CPHA modes; define SPI_SLAVE_BURST_EN for burst auto-increment
module spi_slave_regfile #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_err,
  output logic              addr_err
);
`ifdef SPI_SLAVE_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif
  localparam int HW = $clog2(1 + ADDR_W);
  localparam int DW = $clog2(DATA_W);
  localparam int CW = HW > DW ? HW : DW;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] sck_r, ss_r;
  logic [1:0] mosi_r;
  logic armed, cpol_q, cpha_q, rw, sampled;
  logic [ADDR_W-1:0] hdr, addr, baddr;
  logic [ADDR_W:0] hdr_full;
  logic [DATA_W-1:0] sr, wd, rd_hdr, rd_burst;
  logic [DATA_W-1:0] regs [DEPTH];
  logic ss_fall, ss_rise, lead, trail, samp, shft, in_hdr, in_dat, last_hdr, last_dat;

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // A fall only counts once ss has been seen high after reset, so a reset mid-frame waits for a fresh select
  assign ss_fall  = armed & ss_r[2] & ~ss_r[1];
  assign ss_rise  = ~ss_r[2] & ss_r[1];
  assign lead     = cpol_q ? (sck_r[2] & ~sck_r[1]) : (~sck_r[2] & sck_r[1]);
  assign trail    = cpol_q ? (~sck_r[2] & sck_r[1]) : (sck_r[2] & ~sck_r[1]);
  assign samp     = cpha_q ? trail : lead;
  assign shft     = cpha_q ? lead : trail;
  assign in_hdr   = state == HEADER;
  assign in_dat   = state == DATA;
  assign last_hdr = in_hdr & samp & (cnt == CW'(ADDR_W));
  assign last_dat = in_dat & samp & (cnt == CW'(DATA_W - 1));
  assign hdr_full = {hdr, mosi_r[1]};
  assign wd       = {sr[DATA_W-2:0], mosi_r[1]};
  assign baddr    = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
  assign rd_hdr   = in_rng(hdr_full[ADDR_W-1:0]) ? regs[IW'(hdr_full[ADDR_W-1:0])] : '0;
  assign rd_burst = in_rng(baddr) ? regs[IW'(baddr)] : '0;
  assign busy     = state != IDLE;
  assign miso_oe  = armed & ~ss_r[1];
  assign miso     = miso_oe ? (in_dat & rw & sr[DATA_W-1]) : 1'bz;

  // Two-flop synchronisers plus one extra stage of history for edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_r  <= '0;
      ss_r   <= '0;
      mosi_r <= '0;
      armed  <= 1'b0;
    end else begin
      sck_r  <= {sck_r[1:0], sck};
      ss_r   <= {ss_r[1:0], ss};
      mosi_r <= {mosi_r[0], mosi};
      armed  <= armed | ss_r[1];
    end

  // State and bit-counter register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end

  // Next state: header then data words; ss rising always wins and returns to IDLE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE && ss_fall) begin
      state_n = HEADER;
      cnt_n   = '0;
    end else if ((in_hdr | in_dat) & samp) begin
      cnt_n   = (last_hdr | last_dat) ? '0 : cnt + 1'b1;
      state_n = last_hdr ? DATA : last_dat ? (BURST ? DATA : DRAIN) : state;
    end
    if (ss_rise) state_n = IDLE;
  end

  // Datapath: header decode, shift register, register bank writes and status pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      rw        <= 1'b0;
      sampled   <= 1'b0;
      hdr       <= '0;
      addr      <= '0;
      sr        <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= ss_rise & (in_hdr | in_dat) & (cnt_n != '0);
      addr_err  <= 1'b0;
      if (state == IDLE && ss_fall) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
      if (in_hdr & samp) hdr <= hdr_full[ADDR_W-1:0];
      if (in_dat & samp) begin
        sampled <= 1'b1;
        if (!rw) sr <= wd;
      end
      if (in_dat & rw & shft & sampled) begin
        sr      <= sr << 1;
        sampled <= 1'b0;
      end
      if (last_hdr) begin
        rw       <= hdr_full[ADDR_W];
        addr     <= hdr_full[ADDR_W-1:0];
        addr_err <= !in_rng(hdr_full[ADDR_W-1:0]);
        sr       <= rd_hdr;
        sampled  <= 1'b0;
      end
      if (last_dat) begin
        sampled <= 1'b0;
        if (!rw && in_rng(addr)) begin
          regs[IW'(addr)] <= wd;
          wr_valid        <= 1'b1;
          wr_addr         <= addr;
          wr_data         <= wd;
        end
        if (BURST) begin
          addr     <= baddr;
          addr_err <= !in_rng(baddr);
          if (rw) sr <= rd_burst;
        end
      end
    end
endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

Parametrised SPI slave register file, the next-generation slave for the SPI subsystem.
- Oversamples `sck`, `ss` and `mosi` in the system clock domain and supports all four CPOL/CPHA modes from one datapath.
- Decodes a read/write header and serves a configurable-width, configurable-depth register bank, with optional burst auto-increment.
- Sits on the slave side of the bus, one instance per chip select, and exposes a write-notification port to local logic.

## Interface
- `ADDR_W`, 7: address field width; header is 1 + `ADDR_W` bits.
- `DATA_W`, 8: register and data-word width, ≥2.
- `DEPTH`, 128: number of registers, 1..2^`ADDR_W`.
- `clk` input 1: system clock, single clock domain for the whole block.
- `reset_n` input 1: asynchronous active-low reset.
- `cpol` input 1: clock polarity; latched at `ss` falling.
- `cpha` input 1: clock phase; latched at `ss` falling.
- `ss` input 1: active-low slave select, asynchronous to `clk`.
- `sck` input 1: SPI clock, asynchronous to `clk`.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first; `1'bz` when `miso_oe`=0.
- `miso_oe` output 1: high while `ss` (synchronised) is low.
- `wr_valid` output 1: one-cycle pulse per completed register write.
- `wr_addr` output `ADDR_W`: address of the write.
- `wr_data` output `DATA_W`: data written.
- `busy` output 1: state ≠ IDLE.
- `frame_err` output 1: one-cycle pulse on `ss` rising mid-word.
- `addr_err` output 1: one-cycle pulse when a header or burst address is ≥ `DEPTH`.

## Operation
- **Synchronisation:** `sck`, `ss` and `mosi` pass through 2-FF synchronisers.
- **Edge detection:** an edge detector marks leading and trailing `sck` edges. Leading edge = rising if `cpol`=0, falling if `cpol`=1.
- **Sample and shift edges:** sample edge = leading if `cpha`=0, trailing if `cpha`=1. Shift edge = the other one.
- **Frame format:** header bit 0 is R/W (1 = read), then `ADDR_W` address bits, then data words of `DATA_W` bits.
- **FSM states:** IDLE, HEADER, DATA, DRAIN.
  - IDLE → HEADER: on synchronised `ss` falling. Latch `cpol`/`cpha`; clear the bit counter.
  - HEADER: shift `mosi` in on each sample edge. After bit `ADDR_W`, latch R/W and address, then go to DATA. For reads, load `shift_out` with `reg[addr]` in the same cycle.
  - DATA, write: collect `DATA_W` bits. On the last one, write `reg[addr]` and pulse `wr_valid` with `wr_addr`/`wr_data`.
  - DATA, read: `miso` = `shift_out` MSB. `shift_out` shifts left on the first shift edge after each data-bit sample edge. After the last bit, reload from the next address (burst) or go to DRAIN.
  - DRAIN: ignore all edges; `miso` drives 0.
  - Any state → IDLE: on synchronised `ss` rising. Discard the partial word; no write. Pulse `frame_err` if the bit counter ≠ 0 in HEADER or DATA.
- **Address range:** address ≥ `DEPTH` pulses `addr_err`. Such reads return all-zero and such writes are dropped (no `wr_valid`).
- **Reset:**
  - `reg[i]` = i mod 2^`DATA_W`.
  - State IDLE; `miso_oe`=0, `miso`=z.
  - `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `frame_err`=0, `addr_err`=0.
  - Reset mid-frame aborts with no write. The frame resumes only after a fresh `ss` fall.

## Timing
- **Synchronisation latency:** an edge is acted on 3 `clk` after the pin edge (2 sync + 1 detect).
- **SCK rate limit:** `sck` half-period ≥ 4 `clk`. `ss` setup to the first `sck` edge ≥ 4 `clk`.
- **Write latency:** `wr_valid` asserts 1 `clk` after the detected sample edge of the last data bit.
- **First read bit:** MSB is valid on `miso` ≤ 1 `clk` after the detected last header sample, i.e. before the next shift edge in every mode.
- **Counter widths:** the bit counter is sized `$clog2(1+ADDR_W)` or `$clog2(DATA_W)` bits, whichever is larger. It is cleared at each phase boundary.
- **Burst address:** increments mod `DEPTH`, so `DEPTH-1` wraps to 0.
- **`ss` vs. last bit:** `ss` rising in the same `clk` as the last data-bit sample completes the write first, then returns to IDLE with no `frame_err`.

## Configuration
- **`SPI_SLAVE_BURST_EN` defined:** after each data word the address auto-increments and DATA continues; reads reload `shift_out`. Arbitrary-length bursts end on `ss` rising.
- **`SPI_SLAVE_BURST_EN` undefined:** exactly one data word per frame. After it the FSM enters DRAIN until `ss` rises, and extra bits cause no writes and no errors.

## Test plan
- Mode 0, `DATA_W`=8, read header 1+0x05 → `miso` returns 0x05 MSB first; `wr_valid` never asserts.
- Mode 3, write addr 0x10 data 0xA5, then read 0x10 → `wr_valid` pulse with `wr_addr`=0x10 and `wr_data`=0xA5; readback 0xA5.
- Modes 1 and 2, read addr 0x7F with `DEPTH`=128 → 0x7F. With `SPI_SLAVE_BURST_EN`, the second word is 0x00 (wrap).
- Write header to addr 0x80 with `ADDR_W`=8, `DEPTH`=128 → `addr_err` pulse, no `wr_valid`, reads return 0x00.
- `ss` raised after 5 of 8 data bits → `frame_err` pulse, register unchanged, `busy`=0 within 3 `clk`.
- `reset_n` low mid-write → all outputs at reset values, `miso` = z; next full frame operates normally.
